// File: rtl/mfcc_pkg.sv
// Shared definitions for the MFCC framing front end: FSM encoding,
// Q15 arithmetic widths, the default pre-emphasis coefficient and the
// fixed-point scaling helper.
package mfcc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } framer_state_t;

    // Q15 sample format and the widths used by the pre-emphasis datapath.
    localparam int Q15_W    = 16;
    localparam int Q15_FRAC = 15;
    localparam int PROD_W   = 32;
    localparam int SUM_W    = PROD_W + 1;

    // Unit value in the difference width, used to build saturation limits.
    localparam logic signed [SUM_W-1:0] SUM_ONE = 33'sd1;

    // alpha = 0.97 in Q15.
    localparam logic signed [15:0] PREEMPH_DEFAULT = 16'sd31785;

    // Multiply two sign-extended operands in a 32-bit product and drop the
    // Q15 fraction with an arithmetic shift (rounds towards minus infinity).
    function automatic logic signed [PROD_W-1:0] q15_scale(
        input logic signed [PROD_W-1:0] a,
        input logic signed [PROD_W-1:0] b
    );
        logic signed [PROD_W-1:0] p;
        p = a * b;
        return p >>> Q15_FRAC;
    endfunction

endpackage

// File: rtl/mfcc_preemph.sv
// First-order pre-emphasis filter y[n] = sat(x[n] - (alpha*x[n-1] >>> 15)).
// A sample is consumed when en is high; the filtered value appears on y one
// cycle later, qualified by y_valid. x[n-1] only moves on consumed samples.
module mfcc_preemph
    import mfcc_pkg::*;
#(
    parameter int                 DATA_W  = Q15_W,
    parameter logic signed [15:0] PREEMPH = PREEMPH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y,
    output logic                     y_valid
);

    localparam logic signed [SUM_W-1:0] SAT_MAX_S = (SUM_ONE <<< (DATA_W - 1)) - SUM_ONE;
    localparam logic signed [SUM_W-1:0] SAT_MIN_S = -(SUM_ONE <<< (DATA_W - 1));

    logic signed [DATA_W-1:0] x_prev_r;
    logic signed [DATA_W-1:0] y_r;
    logic                     y_valid_r;

    logic signed [PROD_W-1:0] x_ext_s;
    logic signed [PROD_W-1:0] prev_ext_s;
    logic signed [PROD_W-1:0] scaled_s;
    logic signed [SUM_W-1:0]  diff_s;
    logic signed [DATA_W-1:0] sat_s;

    // Scale the previous sample, subtract, and clamp into the sample range.
    always_comb begin
        x_ext_s    = PROD_W'(x);
        prev_ext_s = PROD_W'(x_prev_r);
        scaled_s   = q15_scale(PROD_W'(PREEMPH), prev_ext_s);
        diff_s     = SUM_W'(x_ext_s) - SUM_W'(scaled_s);
        if (diff_s > SAT_MAX_S) begin
            sat_s = SAT_MAX_S[DATA_W-1:0];
        end else if (diff_s < SAT_MIN_S) begin
            sat_s = SAT_MIN_S[DATA_W-1:0];
        end else begin
            sat_s = diff_s[DATA_W-1:0];
        end
    end

    // Register the filtered sample and remember x[n-1] for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_prev_r  <= {DATA_W{1'b0}};
            y_r       <= {DATA_W{1'b0}};
            y_valid_r <= 1'b0;
        end else if (en) begin
            x_prev_r  <= x;
            y_r       <= sat_s;
            y_valid_r <= 1'b1;
        end else begin
            y_valid_r <= 1'b0;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;

endmodule

// File: rtl/mfcc_framer.sv
// Audio framer: pre-emphasises the input stream, stores it in a circular
// buffer and replays overlapping frames of FRAME_LEN samples, each frame
// starting HOP samples after the previous one.
module mfcc_framer
    import mfcc_pkg::*;
#(
    parameter int                 DATA_W    = Q15_W,
    parameter int                 FRAME_LEN = 256,
    parameter int                 HOP       = 128,
    parameter int                 BUF_DEPTH = 512,
    parameter logic signed [15:0] PREEMPH   = PREEMPH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] sample_in,
    input  logic                     sample_valid,
    output logic                     sample_ready,
    output logic        [DATA_W-1:0] frame_out,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic                     frame_first,
    output logic                     frame_last,
    output logic        [15:0]       frame_count,
    output logic                     overrun
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int OW = AW + 1;
    localparam int IW = $clog2(FRAME_LEN);
    localparam int CW = IW + 1;

    localparam logic [OW-1:0] FRAME_LEN_O = OW'(FRAME_LEN);
    localparam logic [OW-1:0] HOP_O       = OW'(HOP);
    localparam logic [OW-1:0] DEPTH_O     = OW'(BUF_DEPTH);
    localparam logic [OW-1:0] ONE_O       = OW'(1);
    localparam logic [AW-1:0] HOP_A       = AW'(HOP);
    localparam logic [AW-1:0] ONE_A       = AW'(1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(FRAME_LEN - 1);
    localparam logic [IW-1:0] ONE_I       = IW'(1);
    localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);
    localparam logic [CW-1:0] ISS_LAST    = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] ONE_C       = CW'(1);

    // Sample storage; contents are never reset, only the pointers are.
    logic [DATA_W-1:0] mem_r [BUF_DEPTH];

    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_base_r;
    logic [OW-1:0]     occ_r;
    logic [IW-1:0]     idx_r;
    logic [CW-1:0]     iss_cnt_r;
    framer_state_t     state_r;
    logic              sample_ready_r;
    logic              overrun_r;
    logic [DATA_W-1:0] frame_out_r;
    logic              frame_valid_r;
    logic              frame_first_r;
    logic              frame_last_r;
    logic [15:0]       frame_count_r;

    logic signed [DATA_W-1:0] y_s;
    logic                     y_valid_s;
    logic                     accept_s;
    logic                     hs_s;
    logic                     release_s;
    logic                     load_s;
    logic [AW-1:0]            rd_addr_s;
    logic [OW-1:0]            occ_next_s;
    logic                     ready_next_s;

    mfcc_preemph #(
        .DATA_W  (DATA_W),
        .PREEMPH (PREEMPH)
    ) u_preemph (
        .clk     (clk),
        .rst_n   (rst),
        .en      (accept_s),
        .x       (sample_in),
        .y       (y_s),
        .y_valid (y_valid_s)
    );

    // Handshake decode, read addressing and next occupancy. A write and a
    // HOP release on the same edge both apply. Ready is computed one cycle
    // ahead from the next occupancy plus the write that this cycle's accept
    // will produce, so the registered flag is exact.
    always_comb begin
        accept_s  = sample_valid & sample_ready_r;
        hs_s      = frame_valid_r & frame_ready;
        release_s = hs_s & (idx_r == IDX_LAST);
        load_s    = (state_r == ST_STREAM) && (iss_cnt_r < FRAME_LEN_C) &&
                    (!frame_valid_r || frame_ready);
        rd_addr_s = rd_base_r + AW'(iss_cnt_r);
        occ_next_s = occ_r;
        if (y_valid_s) begin
            occ_next_s = occ_next_s + ONE_O;
        end else begin
            occ_next_s = occ_next_s;
        end
        if (release_s) begin
            occ_next_s = occ_next_s - HOP_O;
        end else begin
            occ_next_s = occ_next_s;
        end
        ready_next_s = (occ_next_s + OW'(accept_s)) < DEPTH_O;
    end

    // Buffer write port: the registered pre-emphasis output lands at wr_ptr.
    always_ff @(posedge clk) begin
        if (y_valid_s) begin
            mem_r[wr_ptr_r] <= y_s;
        end
    end

    // Write pointer, occupancy, input flow control and the sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r       <= {AW{1'b0}};
            occ_r          <= {OW{1'b0}};
            sample_ready_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            if (y_valid_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_A;
            end
            occ_r          <= occ_next_s;
            sample_ready_r <= ready_next_s;
            if (sample_valid && !sample_ready_r) begin
                overrun_r <= 1'b1;
            end
        end
    end

    // Frame sequencer: waits for a full frame, then streams it through a
    // one-deep output register that refills on the same edge it is consumed,
    // giving one sample per cycle while the consumer is ready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            rd_base_r     <= {AW{1'b0}};
            idx_r         <= {IW{1'b0}};
            iss_cnt_r     <= {CW{1'b0}};
            frame_out_r   <= {DATA_W{1'b0}};
            frame_valid_r <= 1'b0;
            frame_first_r <= 1'b0;
            frame_last_r  <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    idx_r     <= {IW{1'b0}};
                    iss_cnt_r <= {CW{1'b0}};
                    if (occ_r >= FRAME_LEN_O) begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (load_s) begin
                        frame_out_r   <= mem_r[rd_addr_s];
                        frame_first_r <= (iss_cnt_r == {CW{1'b0}});
                        frame_last_r  <= (iss_cnt_r == ISS_LAST);
                        frame_valid_r <= 1'b1;
                        iss_cnt_r     <= iss_cnt_r + ONE_C;
                    end else if (hs_s) begin
                        frame_valid_r <= 1'b0;
                        frame_first_r <= 1'b0;
                        frame_last_r  <= 1'b0;
                    end
                    if (hs_s) begin
                        if (idx_r == IDX_LAST) begin
                            idx_r         <= {IW{1'b0}};
                            rd_base_r     <= rd_base_r + HOP_A;
                            frame_count_r <= frame_count_r + 16'd1;
                            state_r       <= ST_IDLE;
                        end else begin
                            idx_r <= idx_r + ONE_I;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign sample_ready = sample_ready_r;
    assign overrun      = overrun_r;
    assign frame_out    = frame_out_r;
    assign frame_valid  = frame_valid_r;
    assign frame_first  = frame_first_r;
    assign frame_last   = frame_last_r;
    assign frame_count  = frame_count_r;

endmodule
